// File: rtl/uart_rx_pkg.sv
// Shared types and parameter limits for the UART receive frame checker.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int DATA_W_MIN    = 5;
  localparam int DATA_W_MAX    = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  localparam int CNT_W_MIN     = 1;
  localparam int CNT_W_MAX     = 16;

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/frame_check.sv
// Checks a sampled UART frame (data, optional parity, stop bits) and reports errors.
// Error counters exist only when FRAME_CHECK_ERR_CNT_EN is defined.
module frame_check
  import uart_rx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              sampled_bit,
  input  logic              par_en,
  input  logic              par_odd,
  input  logic              cnt_clr,
  output logic              busy,
  output logic              frame_valid,
  output logic [DATA_W-1:0] data,
  output logic              par_err,
  output logic              stop_err
`ifdef FRAME_CHECK_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  stop_err_cnt
`endif
);

  if (!in_range(DATA_W, DATA_W_MIN, DATA_W_MAX)) begin : g_bad_data_w
    $error("frame_check: DATA_W out of range");
  end
  if (!in_range(STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX)) begin : g_bad_stop_bits
    $error("frame_check: STOP_BITS out of range");
  end
  if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
    $error("frame_check: CNT_W out of range");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DATA_W - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  // start and bit_valid are single-cycle strobes with no ready/backpressure:
  // a strobe is consumed in the cycle it is high or it is lost.
  state_t            state, state_d;
  logic [3:0]        bit_cnt, bit_cnt_d;
  logic              stop_cnt, stop_cnt_d;
  logic [DATA_W-1:0] shreg, shreg_d, data_d;
  logic              acc, acc_d;
  logic              par_en_q, par_en_d;
  logic              perr_f, perr_d, serr_f, serr_d;
  logic              frame_valid_d, par_err_d, stop_err_d;

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    stop_cnt_d    = stop_cnt;
    shreg_d       = shreg;
    acc_d         = acc;
    par_en_d      = par_en_q;
    perr_d        = perr_f;
    serr_d        = serr_f;
    frame_valid_d = 1'b0;
    data_d        = data;
    par_err_d     = par_err;
    stop_err_d    = stop_err;
    if (!EN) begin
      state_d    = ST_IDLE;
      data_d     = '0;
      par_err_d  = 1'b0;
      stop_err_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
            par_en_d   = par_en;
            // Preloading with par_odd makes a zero result mean "parity good" for both senses.
            acc_d      = par_odd;
            perr_d     = 1'b0;
            serr_d     = 1'b0;
          end
        end
        ST_DATA: begin
          if (bit_valid) begin
            shreg_d   = {sampled_bit, shreg[DATA_W-1:1]};
            acc_d     = acc ^ sampled_bit;
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            perr_d  = acc ^ sampled_bit;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_valid) begin
            serr_d     = serr_f | ~sampled_bit;
            stop_cnt_d = stop_cnt + 1'b1;
            if (stop_cnt == LAST_STOP) begin
              state_d       = ST_IDLE;
              frame_valid_d = 1'b1;
              data_d        = shreg;
              par_err_d     = par_en_q & perr_f;
              stop_err_d    = serr_f | ~sampled_bit;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shreg       <= '0;
      acc         <= 1'b0;
      par_en_q    <= 1'b0;
      perr_f      <= 1'b0;
      serr_f      <= 1'b0;
      frame_valid <= 1'b0;
      data        <= '0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      stop_cnt    <= stop_cnt_d;
      shreg       <= shreg_d;
      acc         <= acc_d;
      par_en_q    <= par_en_d;
      perr_f      <= perr_d;
      serr_f      <= serr_d;
      frame_valid <= frame_valid_d;
      data        <= data_d;
      par_err     <= par_err_d;
      stop_err    <= stop_err_d;
    end
  end

`ifdef FRAME_CHECK_ERR_CNT_EN
  // Counting is gated by EN so a disabled block leaves the counts untouched.
  logic par_inc, stop_inc;
  assign par_inc  = EN & frame_valid & par_err;
  assign stop_inc = EN & frame_valid & stop_err;

  sat_counter #(.W(CNT_W)) u_par_cnt (
    .clk (clk),
    .rst (rst),
    .inc (par_inc),
    .clr (cnt_clr),
    .cnt (par_err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stop_inc),
    .clr (cnt_clr),
    .cnt (stop_err_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_frame_check.sv
// Bench for frame_check: two instances (1 stop bit / CNT_W=8, 2 stop bits / CNT_W=2).
module tb_frame_check;

  logic       clk, rst;
  logic       en[2], start_s[2], bv[2], sb[2], pen[2], podd[2], cclr[2];
  logic       busy_o[2], fv[2], perr_o[2], serr_o[2];
  logic [7:0] data_o[2];
`ifdef FRAME_CHECK_ERR_CNT_EN
  logic [7:0] pcnt0, scnt0;
  logic [1:0] pcnt1, scnt1;
`endif

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int pcnt_m[2], scnt_m[2];

  frame_check #(.DATA_W(8), .STOP_BITS(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .EN(en[0]), .start(start_s[0]), .bit_valid(bv[0]),
    .sampled_bit(sb[0]), .par_en(pen[0]), .par_odd(podd[0]), .cnt_clr(cclr[0]),
    .busy(busy_o[0]), .frame_valid(fv[0]), .data(data_o[0]),
    .par_err(perr_o[0]), .stop_err(serr_o[0])
`ifdef FRAME_CHECK_ERR_CNT_EN
    , .par_err_cnt(pcnt0), .stop_err_cnt(scnt0)
`endif
  );

  frame_check #(.DATA_W(8), .STOP_BITS(2), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .EN(en[1]), .start(start_s[1]), .bit_valid(bv[1]),
    .sampled_bit(sb[1]), .par_en(pen[1]), .par_odd(podd[1]), .cnt_clr(cclr[1]),
    .busy(busy_o[1]), .frame_valid(fv[1]), .data(data_o[1]),
    .par_err(perr_o[1]), .stop_err(serr_o[1])
`ifdef FRAME_CHECK_ERR_CNT_EN
    , .par_err_cnt(pcnt1), .stop_err_cnt(scnt1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // reference model: frame result {data, par_err, stop_err} from the line bits
  function automatic logic [9:0] model_frame(input logic [7:0] d, input logic pe, input logic po,
                                             input logic pbit, input logic [1:0] stops, input int nstop);
    logic perr, serr;
    perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(po));
    serr = (nstop == 2) ? !(stops[0] && stops[1]) : !stops[0];
    return {d, perr, serr};
  endfunction

  // scoreboard: every frame_valid pulse consumes exactly one expected frame
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (fv[0] === 1'b1) begin
        if (exp_q0.size() == 0) chk("fv_unexpected0", 16'(fv[0]), 16'h0);
        else begin
          e = exp_q0.pop_front();
          chk("frame0", {6'h0, data_o[0], perr_o[0], serr_o[0]}, {6'h0, e});
        end
      end
      if (fv[1] === 1'b1) begin
        if (exp_q1.size() == 0) chk("fv_unexpected1", 16'(fv[1]), 16'h0);
        else begin
          e = exp_q1.pop_front();
          chk("frame1", {6'h0, data_o[1], perr_o[1], serr_o[1]}, {6'h0, e});
        end
      end
    end
  end

  task automatic strobe(input int u, input logic b, input bit inj_start);
    repeat ($urandom_range(0, 2)) tick();
    bv[u] = 1'b1;
    sb[u] = b;
    start_s[u] = inj_start;
    tick();
    bv[u] = 1'b0;
    start_s[u] = 1'b0;
    sb[u] = 1'($urandom_range(0, 1));
  endtask

  task automatic check_counters(input int u);
`ifdef FRAME_CHECK_ERR_CNT_EN
    if (u == 0) begin
      chk("par_cnt0", 16'(pcnt0), 16'(pcnt_m[0]));
      chk("stop_cnt0", 16'(scnt0), 16'(scnt_m[0]));
    end else begin
      chk("par_cnt1", 16'(pcnt1), 16'(pcnt_m[1]));
      chk("stop_cnt1", 16'(scnt1), 16'(scnt_m[1]));
    end
`endif
  endtask

  task automatic send_frame(input int u, input logic [7:0] d, input logic pe, input logic po,
                            input logic pbit, input logic [1:0] stops, input logic [9:0] expv,
                            input bit inject, input bit clr);
    int nstop;
    int maxc;
    nstop = (u == 1) ? 2 : 1;
    maxc = (u == 1) ? 3 : 255;
    if ($urandom_range(0, 1) == 1) begin
      bv[u] = 1'b1;
      tick();
      bv[u] = 1'b0;
    end
    pen[u] = pe;
    podd[u] = po;
    start_s[u] = 1'b1;
    bv[u] = 1'($urandom_range(0, 1));
    tick();
    start_s[u] = 1'b0;
    bv[u] = 1'b0;
    pen[u] = 1'($urandom_range(0, 1));
    podd[u] = 1'($urandom_range(0, 1));
    chk("busy_in_frame", 16'(busy_o[u]), 16'h1);
    for (int i = 0; i < 8; i++) strobe(u, d[i], inject && (i == 3));
    if (pe) strobe(u, pbit, inject);
    for (int s = 0; s < nstop; s++) begin
      if (s == nstop - 1) begin
        if (u == 0) exp_q0.push_back(expv);
        else exp_q1.push_back(expv);
      end
      strobe(u, stops[s], 1'b0);
      if (s < nstop - 1) chk("fv_early", 16'(fv[u]), 16'h0);
    end
    chk("fv_timing", 16'(fv[u]), 16'h1);
    chk("busy_after", 16'(busy_o[u]), 16'h0);
    cclr[u] = clr;
    tick();
    cclr[u] = 1'b0;
    chk("fv_one_cycle", 16'(fv[u]), 16'h0);
    if (clr) begin
      pcnt_m[u] = 0;
      scnt_m[u] = 0;
    end else begin
      if (expv[1] && pcnt_m[u] < maxc) pcnt_m[u]++;
      if (expv[0] && scnt_m[u] < maxc) scnt_m[u]++;
    end
    check_counters(u);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      en[u] = 1'b1; start_s[u] = 1'b0; bv[u] = 1'b0; sb[u] = 1'b0;
      pen[u] = 1'b0; podd[u] = 1'b0; cclr[u] = 1'b0;
      pcnt_m[u] = 0; scnt_m[u] = 0;
    end
    repeat (2) tick();
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy", 16'(busy_o[u]), 16'h0);
      chk("rst_fv", 16'(fv[u]), 16'h0);
      chk("rst_data", 16'(data_o[u]), 16'h0);
      chk("rst_errs", {14'h0, perr_o[u], serr_o[u]}, 16'h0);
      check_counters(u);
    end
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    int         u;
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       pbit;
    logic [1:0] stops;
    logic [9:0] expv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] rd;
    logic       rpe, rpo, rpb;
    logic [1:0] rst_bits;
    int         ru;

    tbl[0] = '{0, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b01, {8'hA5, 1'b0, 1'b0}};
    tbl[1] = '{0, 8'h01, 1'b1, 1'b1, 1'b1, 2'b01, {8'h01, 1'b1, 1'b0}};
    tbl[2] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b01, {8'h3C, 1'b0, 1'b0}};
    tbl[3] = '{0, 8'hFF, 1'b1, 1'b0, 1'b0, 2'b00, {8'hFF, 1'b0, 1'b1}};
    tbl[4] = '{1, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, {8'h5A, 1'b0, 1'b1}};
    tbl[5] = '{1, 8'h80, 1'b1, 1'b1, 1'b0, 2'b11, {8'h80, 1'b0, 1'b0}};
    tbl[6] = '{0, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, {8'h00, 1'b1, 1'b0}};
    tbl[7] = '{1, 8'hC3, 1'b1, 1'b0, 1'b1, 2'b10, {8'hC3, 1'b1, 1'b1}};

    do_reset();

    for (int i = 0; i < 8; i++)
      send_frame(tbl[i].u, tbl[i].d, tbl[i].pe, tbl[i].po, tbl[i].pbit, tbl[i].stops,
                 tbl[i].expv, 1'b0, 1'b0);

    // saturation on the 2-bit counter, then clear racing a new error
    do_reset();
    for (int i = 0; i < 4; i++)
      send_frame(1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 2'b01, {8'h11 + 8'(i), 1'b0, 1'b1}, 1'b0, 1'b0);
    send_frame(1, 8'h77, 1'b0, 1'b0, 1'b0, 2'b01, {8'h77, 1'b0, 1'b1}, 1'b0, 1'b1);

    // reset in the middle of a frame
    send_frame(0, 8'h42, 1'b0, 1'b0, 1'b0, 2'b01, {8'h42, 1'b0, 1'b0}, 1'b0, 1'b0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) strobe(0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 16'(busy_o[0]), 16'h0);
    chk("midrst_data", 16'(data_o[0]), 16'h0);
    tick();
    rst = 1'b0;
    pcnt_m[0] = 0; scnt_m[0] = 0; pcnt_m[1] = 0; scnt_m[1] = 0;
    tick();
    send_frame(0, 8'h96, 1'b1, 1'b0, 1'b0, 2'b01, {8'h96, 1'b0, 1'b0}, 1'b0, 1'b0);

    // EN dropped mid-frame, then a clean frame with a stray start inside it
    send_frame(0, 8'h01, 1'b1, 1'b1, 1'b1, 2'b00, {8'h01, 1'b1, 1'b1}, 1'b0, 1'b0);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) strobe(0, 1'b0, 1'b0);
    en[0] = 1'b0;
    tick();
    chk("en_busy", 16'(busy_o[0]), 16'h0);
    chk("en_data", 16'(data_o[0]), 16'h0);
    chk("en_errs", {14'h0, perr_o[0], serr_o[0]}, 16'h0);
    check_counters(0);
    en[0] = 1'b1;
    tick();
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b01, {8'h3C, 1'b0, 1'b0}, 1'b1, 1'b0);

    // randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      ru = int'($urandom_range(0, 1));
      rd = 8'($urandom_range(0, 255));
      rpe = 1'($urandom_range(0, 1));
      rpo = 1'($urandom_range(0, 1));
      rpb = 1'($urandom_range(0, 1));
      rst_bits = 2'($urandom_range(0, 3));
      send_frame(ru, rd, rpe, rpo, rpb, rst_bits,
                 model_frame(rd, rpe, rpo, rpb, rst_bits, (ru == 1) ? 2 : 1),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    repeat (4) tick();
    chk("q_empty0", 16'(exp_q0.size()), 16'h0);
    chk("q_empty1", 16'(exp_q1.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
